// File: rtl/branch_rs_param.sv
// Branch reservation station: holds branches until both operands arrive via two CDB snoop ports.
// Issues the oldest ready entry into a registered result slot, one cycle after its operands are stored.
module branch_rs_param #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 6,
  parameter int TAG_NONE = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [TAG_W-1:0]           disp_rob,
  input  logic [2:0]                 disp_subop,
  input  logic [DATA_W-1:0]          disp_v1,
  input  logic [DATA_W-1:0]          disp_v2,
  input  logic [TAG_W-1:0]           disp_q1,
  input  logic [TAG_W-1:0]           disp_q2,
  input  logic                       cdb0_valid,
  input  logic [TAG_W-1:0]           cdb0_tag,
  input  logic [DATA_W-1:0]          cdb0_data,
  input  logic                       cdb1_valid,
  input  logic [TAG_W-1:0]           cdb1_tag,
  input  logic [DATA_W-1:0]          cdb1_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [TAG_W-1:0]           res_rob,
  output logic                       res_taken,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] TNONE = TAG_W'(TAG_NONE);

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [TAG_W-1:0]  rob_q [DEPTH], rob_d [DEPTH];
  logic [2:0]        op_q  [DEPTH], op_d  [DEPTH];
  logic [DATA_W-1:0] v1_q  [DEPTH], v1_d  [DEPTH];
  logic [DATA_W-1:0] v2_q  [DEPTH], v2_d  [DEPTH];
  logic [TAG_W-1:0]  q1_q  [DEPTH], q1_d  [DEPTH];
  logic [TAG_W-1:0]  q2_q  [DEPTH], q2_d  [DEPTH];
  // older_q[i][j] set when entry j was dispatched before entry i
  logic [DEPTH-1:0]  older_q [DEPTH], older_d [DEPTH];
  logic              res_valid_q, res_valid_d;
  logic              res_taken_q, res_taken_d;
  logic [TAG_W-1:0]  res_rob_q, res_rob_d;
  logic [CW-1:0]     count_q, count_d;

  logic [DEPTH-1:0]  rdy;
  logic              sel_vld;
  logic [IW-1:0]     sel_idx, free_idx;
  logic              issue, disp_acc;

  function automatic logic [TAG_W+DATA_W-1:0] snoop(
    input logic [TAG_W-1:0] q, input logic [DATA_W-1:0] v,
    input logic c0v, input logic [TAG_W-1:0] c0t, input logic [DATA_W-1:0] c0d,
    input logic c1v, input logic [TAG_W-1:0] c1t, input logic [DATA_W-1:0] c1d);
    logic [TAG_W+DATA_W-1:0] r;
    r = {q, v};
    if (q != TNONE) begin
      if (c0v && c0t == q)      r = {TNONE, c0d};
      else if (c1v && c1t == q) r = {TNONE, c1d};
    end
    return r;
  endfunction

  function automatic logic br_taken(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    case (op)
      3'b000:  br_taken = (a == b);
      3'b001:  br_taken = (a != b);
      3'b100:  br_taken = ($signed(a) <  $signed(b));
      3'b101:  br_taken = ($signed(a) >= $signed(b));
      3'b110:  br_taken = (a <  b);
      3'b111:  br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  endfunction

  assign disp_ready = (count_q < CW'(DEPTH));
  assign res_valid  = res_valid_q;
  assign res_rob    = res_rob_q;
  assign res_taken  = res_taken_q;
  assign count      = count_q;

  // Selection sees only registered operands, so a CDB wakeup costs one cycle before issue.
  always_comb begin
    rdy      = '0;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      rdy[i] = busy_q[i] && (q1_q[i] == TNONE) && (q2_q[i] == TNONE);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i] && !(|(rdy & older_q[i]))) begin
        sel_vld = 1'b1;
        sel_idx = IW'(i);
      end
      if (!busy_q[i]) free_idx = IW'(i);
    end
  end

  always_comb begin
    busy_d      = busy_q;
    rob_d       = rob_q;
    op_d        = op_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    q1_d        = q1_q;
    q2_d        = q2_q;
    older_d     = older_q;
    res_valid_d = res_valid_q;
    res_rob_d   = res_rob_q;
    res_taken_d = res_taken_q;
    count_d     = '0;
    issue       = sel_vld && (!res_valid_q || res_ready);
    disp_acc    = disp_valid && disp_ready;

    for (int i = 0; i < DEPTH; i++) begin
      {q1_d[i], v1_d[i]} = snoop(q1_q[i], v1_q[i], cdb0_valid, cdb0_tag, cdb0_data,
                                 cdb1_valid, cdb1_tag, cdb1_data);
      {q2_d[i], v2_d[i]} = snoop(q2_q[i], v2_q[i], cdb0_valid, cdb0_tag, cdb0_data,
                                 cdb1_valid, cdb1_tag, cdb1_data);
    end

    if (issue) begin
      busy_d[sel_idx] = 1'b0;
      res_valid_d     = 1'b1;
      res_rob_d       = rob_q[sel_idx];
      res_taken_d     = br_taken(op_q[sel_idx], v1_q[sel_idx], v2_q[sel_idx]);
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end

    if (disp_acc) begin
      busy_d[free_idx] = 1'b1;
      rob_d[free_idx]  = disp_rob;
      op_d[free_idx]   = disp_subop;
      {q1_d[free_idx], v1_d[free_idx]} = snoop(disp_q1, disp_v1, cdb0_valid, cdb0_tag,
                                               cdb0_data, cdb1_valid, cdb1_tag, cdb1_data);
      {q2_d[free_idx], v2_d[free_idx]} = snoop(disp_q2, disp_v2, cdb0_valid, cdb0_tag,
                                               cdb0_data, cdb1_valid, cdb1_tag, cdb1_data);
      older_d[free_idx] = busy_q;
      for (int j = 0; j < DEPTH; j++)
        if (j != int'(free_idx)) older_d[j][free_idx] = 1'b0;
    end

    if (flush) begin
      busy_d      = '0;
      res_valid_d = 1'b0;
      res_rob_d   = TNONE;
      res_taken_d = 1'b0;
    end

    for (int i = 0; i < DEPTH; i++)
      count_d = count_d + CW'(busy_d[i]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      res_valid_q <= 1'b0;
      res_rob_q   <= TNONE;
      res_taken_q <= 1'b0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i]   <= '0;
        op_q[i]    <= '0;
        v1_q[i]    <= '0;
        v2_q[i]    <= '0;
        q1_q[i]    <= TNONE;
        q2_q[i]    <= TNONE;
        older_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      rob_q       <= rob_d;
      op_q        <= op_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      older_q     <= older_d;
      res_valid_q <= res_valid_d;
      res_rob_q   <= res_rob_d;
      res_taken_q <= res_taken_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_branch_rs_param.sv
// Bench for branch_rs_param: directed scenarios plus random traffic against an age-ordered queue model.
module tb_branch_rs_param;
  localparam int DEPTH = 4;
  localparam logic [5:0] NONE = 6'd16;

  logic        clock = 1'b0, reset = 1'b1, flush = 1'b0;
  logic        disp_valid = 1'b0, disp_ready;
  logic [5:0]  disp_rob = '0, disp_q1 = NONE, disp_q2 = NONE;
  logic [2:0]  disp_subop = '0;
  logic [31:0] disp_v1 = '0, disp_v2 = '0;
  logic        cdb0_valid = 1'b0, cdb1_valid = 1'b0;
  logic [5:0]  cdb0_tag = '0, cdb1_tag = '0;
  logic [31:0] cdb0_data = '0, cdb1_data = '0;
  logic        res_valid, res_ready = 1'b0, res_taken;
  logic [5:0]  res_rob;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0]  rob;
    logic [2:0]  op;
    logic [31:0] v1, v2;
    logic [5:0]  q1, q2;
  } ent_t;

  ent_t       mq[$];
  logic       m_valid = 1'b0;
  logic [5:0] m_rob   = NONE;
  logic       m_taken = 1'b0;

  branch_rs_param #(.DEPTH(DEPTH), .DATA_W(32), .TAG_W(6), .TAG_NONE(16)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rob(disp_rob),
    .disp_subop(disp_subop), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_q1(disp_q1), .disp_q2(disp_q2),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_rob(res_rob),
    .res_taken(res_taken), .count(count)
  );

  always #5 clock = ~clock;

  function automatic logic ref_taken(ent_t e);
    case (e.op)
      3'd0: return e.v1 == e.v2;
      3'd1: return e.v1 != e.v2;
      3'd4: return $signed(e.v1) <  $signed(e.v2);
      3'd5: return $signed(e.v1) >= $signed(e.v2);
      3'd6: return e.v1 <  e.v2;
      3'd7: return e.v1 >= e.v2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ent_t ref_wake(ent_t e);
    ent_t r = e;
    if (r.q1 != NONE) begin
      if (cdb0_valid && cdb0_tag == r.q1)      begin r.v1 = cdb0_data; r.q1 = NONE; end
      else if (cdb1_valid && cdb1_tag == r.q1) begin r.v1 = cdb1_data; r.q1 = NONE; end
    end
    if (r.q2 != NONE) begin
      if (cdb0_valid && cdb0_tag == r.q2)      begin r.v2 = cdb0_data; r.q2 = NONE; end
      else if (cdb1_valid && cdb1_tag == r.q2) begin r.v2 = cdb1_data; r.q2 = NONE; end
    end
    return r;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_valid = 1'b0;
    m_rob   = NONE;
    m_taken = 1'b0;
  endtask

  // Queue is kept in dispatch order, so the oldest ready entry is the first ready one found.
  always @(posedge clock) begin : model
    int   sel;
    int   n_old;
    bit   iss;
    ent_t e;
    if (reset || flush) begin
      model_clear();
    end else begin
      n_old = mq.size();
      sel   = -1;
      for (int k = 0; k < mq.size(); k++)
        if (sel < 0 && mq[k].q1 == NONE && mq[k].q2 == NONE) sel = k;
      iss = (sel >= 0) && (!m_valid || res_ready);
      if (iss) begin
        m_valid = 1'b1;
        m_rob   = mq[sel].rob;
        m_taken = ref_taken(mq[sel]);
      end else if (res_ready) begin
        m_valid = 1'b0;
      end
      for (int k = 0; k < mq.size(); k++) mq[k] = ref_wake(mq[k]);
      if (iss) mq.delete(sel);
      if (disp_valid && n_old < DEPTH) begin
        e = '{disp_rob, disp_subop, disp_v1, disp_v2, disp_q1, disp_q2};
        mq.push_back(ref_wake(e));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb0_valid = 1'b0;
    cdb1_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic disp(input logic [5:0] rob, input logic [2:0] op, input logic [31:0] v1,
                      input logic [31:0] v2, input logic [5:0] q1, input logic [5:0] q2);
    disp_valid = 1'b1;
    disp_rob   = rob;
    disp_subop = op;
    disp_v1    = v1;
    disp_v2    = v2;
    disp_q1    = q1;
    disp_q2    = q2;
  endtask

  task automatic drain();
    idle();
    res_ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    total++;
    if (res_valid !== 1'b0 || res_rob !== NONE || res_taken !== 1'b0) begin
      bad++;
      $display("FAIL reset_res valid=%0b rob=%0d taken=%0b want 0/16/0", res_valid, res_rob, res_taken);
    end
    total++;
    if (count !== 3'd0 || disp_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_count count=%0d ready=%0b want 0/1", count, disp_ready);
    end
  endtask

  task automatic test_bne();
    idle();
    res_ready = 1'b1;
    disp(6'd5, 3'b001, 32'd5, 32'd7, NONE, NONE);
    tick();
    idle();
    total++;
    if (res_valid !== 1'b0 || count !== 3'd1) begin
      bad++;
      $display("FAIL bne_first_edge valid=%0b count=%0d want 0/1", res_valid, count);
    end
    tick();
    total++;
    if (res_valid !== 1'b1 || res_rob !== 6'd5 || res_taken !== 1'b1) begin
      bad++;
      $display("FAIL bne_result valid=%0b rob=%0d taken=%0b want 1/5/1", res_valid, res_rob, res_taken);
    end
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL bne_count count=%0d want 0", count);
    end
    tick();
    total++;
    if (res_valid !== 1'b0) begin
      bad++;
      $display("FAIL bne_drop valid=%0b want 0", res_valid);
    end
  endtask

  task automatic test_blt_cdb();
    logic [2:0] ops [2]  = '{3'b100, 3'b110};
    logic       want [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      idle();
      res_ready = 1'b1;
      disp(6'(6 + k), ops[k], 32'hFFFF_FFFF, 32'd0, NONE, 6'd9);
      tick();
      idle();
      cdb1_valid = 1'b1;
      cdb1_tag   = 6'd9;
      cdb1_data  = 32'd1;
      tick();
      idle();
      total++;
      if (res_valid !== 1'b0) begin
        bad++;
        $display("FAIL blt_no_bypass case=%0d valid=%0b want 0", k, res_valid);
      end
      tick();
      total++;
      if (res_valid !== 1'b1 || res_rob !== 6'(6 + k) || res_taken !== want[k]) begin
        bad++;
        $display("FAIL blt_result case=%0d valid=%0b rob=%0d taken=%0b want 1/%0d/%0b",
                 k, res_valid, res_rob, res_taken, 6 + k, want[k]);
      end
      tick();
    end
  endtask

  task automatic test_full();
    idle();
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp(6'(10 + k), 3'b000, 32'd0, 32'd0, 6'd30, NONE);
      tick();
    end
    idle();
    total++;
    if (count !== 3'd4 || disp_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_count count=%0d ready=%0b want 4/0", count, disp_ready);
    end
    disp(6'd14, 3'b000, 32'd0, 32'd0, NONE, NONE);
    tick();
    idle();
    total++;
    if (count !== 3'd4 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_fifth_ignored count=%0d valid=%0b want 4/0", count, res_valid);
    end
    cdb0_valid = 1'b1;
    cdb0_tag   = 6'd30;
    cdb0_data  = 32'd7;
    tick();
    idle();
    tick();
    total++;
    if (res_valid !== 1'b1 || res_rob !== 6'd10 || res_taken !== 1'b0 || count !== 3'd3) begin
      bad++;
      $display("FAIL full_first_issue valid=%0b rob=%0d taken=%0b count=%0d want 1/10/0/3",
               res_valid, res_rob, res_taken, count);
    end
    res_ready = 1'b1;
    disp(6'd15, 3'b000, 32'd1, 32'd1, NONE, NONE);
    tick();
    idle();
    total++;
    if (count !== 3'd3 || res_rob !== 6'd11) begin
      bad++;
      $display("FAIL full_disp_and_issue count=%0d rob=%0d want 3/11", count, res_rob);
    end
    res_ready = 1'b0;
    disp(6'd17, 3'b000, 32'd1, 32'd1, NONE, NONE);
    tick();
    idle();
    total++;
    if (count !== 3'd4 || res_rob !== 6'd11 || res_valid !== 1'b1) begin
      bad++;
      $display("FAIL full_refill count=%0d rob=%0d valid=%0b want 4/11/1", count, res_rob, res_valid);
    end
    drain();
  endtask

  task automatic test_age_hold();
    idle();
    res_ready = 1'b0;
    disp(6'd22, 3'b000, 32'd0, 32'd0, NONE, NONE);
    tick();
    disp(6'd20, 3'b001, 32'd0, 32'd1, 6'd40, NONE);
    tick();
    disp(6'd21, 3'b001, 32'd2, 32'd0, NONE, 6'd41);
    tick();
    idle();
    cdb0_valid = 1'b1; cdb0_tag = 6'd40; cdb0_data = 32'd3;
    cdb1_valid = 1'b1; cdb1_tag = 6'd41; cdb1_data = 32'd2;
    tick();
    idle();
    res_ready = 1'b1;
    tick();
    total++;
    if (res_valid !== 1'b1 || res_rob !== 6'd20 || res_taken !== 1'b1) begin
      bad++;
      $display("FAIL age_older_first valid=%0b rob=%0d taken=%0b want 1/20/1", res_valid, res_rob, res_taken);
    end
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (res_valid !== 1'b1 || res_rob !== 6'd20 || res_taken !== 1'b1) begin
        bad++;
        $display("FAIL age_hold cyc=%0d valid=%0b rob=%0d taken=%0b want 1/20/1",
                 k, res_valid, res_rob, res_taken);
      end
    end
    res_ready = 1'b1;
    tick();
    total++;
    if (res_valid !== 1'b1 || res_rob !== 6'd21 || res_taken !== 1'b0) begin
      bad++;
      $display("FAIL age_younger_next valid=%0b rob=%0d taken=%0b want 1/21/0", res_valid, res_rob, res_taken);
    end
    tick();
    total++;
    if (res_valid !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL age_drained valid=%0b count=%0d want 0/0", res_valid, count);
    end
  endtask

  task automatic test_capture();
    idle();
    res_ready = 1'b1;
    disp(6'd25, 3'b000, 32'd0, 32'd42, 6'd3, NONE);
    cdb0_valid = 1'b1;
    cdb0_tag   = 6'd3;
    cdb0_data  = 32'd42;
    tick();
    idle();
    total++;
    if (count !== 3'd1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL capture_stored count=%0d valid=%0b want 1/0", count, res_valid);
    end
    tick();
    total++;
    if (res_valid !== 1'b1 || res_rob !== 6'd25 || res_taken !== 1'b1 || count !== 3'd0) begin
      bad++;
      $display("FAIL capture_issue valid=%0b rob=%0d taken=%0b count=%0d want 1/25/1/0",
               res_valid, res_rob, res_taken, count);
    end
    tick();
  endtask

  task automatic test_flush();
    idle();
    res_ready = 1'b0;
    disp(6'd30, 3'b000, 32'd0, 32'd0, NONE, NONE);
    tick();
    for (int k = 0; k < 3; k++) begin
      disp(6'(31 + k), 3'b000, 32'd0, 32'd0, 6'd50, NONE);
      tick();
    end
    idle();
    total++;
    if (count !== 3'd3 || res_valid !== 1'b1 || res_rob !== 6'd30) begin
      bad++;
      $display("FAIL flush_setup count=%0d valid=%0b rob=%0d want 3/1/30", count, res_valid, res_rob);
    end
    flush = 1'b1;
    disp(6'd34, 3'b000, 32'd0, 32'd0, NONE, NONE);
    cdb0_valid = 1'b1;
    cdb0_tag   = 6'd50;
    cdb0_data  = 32'd0;
    tick();
    idle();
    total++;
    if (count !== 3'd0 || res_valid !== 1'b0 || disp_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_clear count=%0d valid=%0b ready=%0b want 0/0/1", count, res_valid, disp_ready);
    end
    tick();
    total++;
    if (count !== 3'd0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_dropped_disp count=%0d valid=%0b want 0/0", count, res_valid);
    end
  endtask

  task automatic test_async_reset();
    idle();
    res_ready = 1'b0;
    disp(6'd38, 3'b000, 32'd0, 32'd0, NONE, NONE);
    tick();
    disp(6'd35, 3'b000, 32'd0, 32'd0, 6'd51, NONE);
    tick();
    disp(6'd36, 3'b000, 32'd0, 32'd0, 6'd51, NONE);
    tick();
    idle();
    total++;
    if (count !== 3'd2 || res_valid !== 1'b1) begin
      bad++;
      $display("FAIL arst_setup count=%0d valid=%0b want 2/1", count, res_valid);
    end
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    total++;
    if (count !== 3'd0 || res_valid !== 1'b0 || res_rob !== NONE || disp_ready !== 1'b1) begin
      bad++;
      $display("FAIL arst_immediate count=%0d valid=%0b rob=%0d ready=%0b want 0/0/16/1",
               count, res_valid, res_rob, disp_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    cdb0_valid = 1'b1;
    cdb0_tag   = 6'd51;
    cdb0_data  = 32'd0;
    res_ready  = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (res_valid !== 1'b0) begin
        bad++;
        $display("FAIL arst_no_result cyc=%0d valid=%0b want 0", k, res_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      disp_valid = ($urandom_range(0, 2) != 0);
      disp_rob   = 6'($urandom_range(0, 63));
      disp_subop = 3'($urandom_range(0, 7));
      disp_v1    = $urandom;
      disp_v2    = ($urandom_range(0, 3) == 0) ? disp_v1 : $urandom;
      disp_q1    = ($urandom_range(0, 1) != 0) ? NONE : 6'(20 + $urandom_range(0, 3));
      disp_q2    = ($urandom_range(0, 1) != 0) ? NONE : 6'(20 + $urandom_range(0, 3));
      cdb0_valid = ($urandom_range(0, 1) != 0);
      cdb0_tag   = ($urandom_range(0, 7) == 0) ? NONE : 6'(20 + $urandom_range(0, 3));
      cdb0_data  = $urandom;
      cdb1_valid = ($urandom_range(0, 1) != 0);
      cdb1_tag   = ($urandom_range(0, 7) == 0) ? NONE : 6'(20 + $urandom_range(0, 3));
      cdb1_data  = $urandom;
      res_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 49) == 0);
      tick();
      total++;
      if (res_valid !== m_valid) begin
        bad++;
        $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", c, res_valid, m_valid);
      end
      if (m_valid) begin
        total++;
        if (res_rob !== m_rob || res_taken !== m_taken) begin
          bad++;
          $display("FAIL rand_result cyc=%0d rob=%0d taken=%0b want %0d/%0b",
                   c, res_rob, res_taken, m_rob, m_taken);
        end
      end
      total++;
      if (count !== 3'(mq.size()) || disp_ready !== (mq.size() < DEPTH)) begin
        bad++;
        $display("FAIL rand_count cyc=%0d count=%0d ready=%0b want %0d", c, count, disp_ready, mq.size());
      end
    end
    idle();
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    test_reset();
    reset = 1'b0;
    test_bne();
    test_blt_cdb();
    test_full();
    test_age_hold();
    test_capture();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
